// File: rtl/temp_sampler.sv
// temp_sampler
//   Periodically reads a 16-bit read-only serial temperature sensor
//   (SPI-style, MSB first). Each frame becomes an unsigned 8-bit
//   whole-degree sample, published with a one-cycle strobe.
//
//   Optional feature macro: TEMP_SAMPLER_FRAME_CHECK_EN
//     defined   : frame bits [1:0] must read 2'b11. A mismatching frame
//                 pulses frame_err instead of publishing.
//     undefined : frame_err stays 0 and every frame publishes.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        level, high = periodic sampling runs
//   sclk          sensor serial clock, idles low
//   cs_n          sensor chip select, active low, idles high
//   miso          sensor serial data
//   sample[7:0]   last converted temperature, unsigned degrees C
//   sample_valid  one-cycle strobe, sample is new this cycle
//   busy          high while cs_n is low
//   frame_err     one-cycle strobe on a bad frame (check build only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not sampling; a high enable starts a frame on the next edge
// WAIT     | frame done, waiting for the sample period to elapse
// CS_SETUP | cs_n low, sclk low, for SCLK_DIV cycles before the first bit
// SHIFT    | 16 sclk periods; miso captured as sclk is driven high
// CS_HOLD  | cs_n low, sclk low, for SCLK_DIV cycles, then publish

module temp_sampler #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SCLK_DIV      = 4,
  parameter int FRAME_BITS    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sclk,
  output logic       cs_n,
  input  logic       miso,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       frame_err
);

  // A frame occupies 34*SCLK_DIV cycles; shorter periods could not fit one.
  localparam int PERIOD_MIN = 34 * SCLK_DIV + 2;
  localparam int PERIOD     = (SAMPLE_PERIOD < PERIOD_MIN) ? PERIOD_MIN : SAMPLE_PERIOD;
  localparam int CNT_W      = $clog2(PERIOD) + 1;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LOAD    = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_BITS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT     = 3'd1;
  localparam logic [2:0] CS_SETUP = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] CS_HOLD  = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      period_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [7:0]            conv_value;
  logic                  frame_ok;

  // Bits [15:7] are a 9-bit two's-complement whole-degree value;
  // negative readings clamp to 0, fractional bits are dropped.
  always_comb begin
    conv_value = shift_reg[15] ? 8'd0 : shift_reg[14:7];
  end

`ifdef TEMP_SAMPLER_FRAME_CHECK_EN
  assign frame_ok = (shift_reg[1:0] == 2'b11);
`else
  assign frame_ok = 1'b1;
`endif

  assign busy = ~cs_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period_cnt   <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      sample       <= 8'd0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      // Free-runs from each frame start; the frame-start branches below
      // override this with 0.
      if (state != IDLE) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state      <= CS_SETUP;
            cs_n       <= 1'b0;
            period_cnt <= '0;
            div_cnt    <= DIV_LOAD;
          end
        end

        WAIT: begin
          if (period_cnt == PERIOD_LAST) begin
            if (enable) begin
              state      <= CS_SETUP;
              cs_n       <= 1'b0;
              period_cnt <= '0;
              div_cnt    <= DIV_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        CS_SETUP: begin
          if (div_cnt == '0) begin
            state   <= SHIFT;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end

        SHIFT: begin
          // sclk itself marks which half of the bit period we are in.
          if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            if (!sclk) begin
              sclk      <= 1'b1;
              shift_reg <= {shift_reg[FRAME_BITS-2:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= CS_HOLD;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end

        CS_HOLD: begin
          if (div_cnt == '0) begin
            state <= WAIT;
            cs_n  <= 1'b1;
            if (frame_ok) begin
              sample       <= conv_value;
              sample_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/temp_sampler.md
Name: temp_sampler

Overview:
- Upstream acquisition stage for the temperature buffer.
- Periodically reads a 16-bit serial temperature sensor (SPI-style, read-only, MSB first), converts each frame to an unsigned 8-bit whole-degree sample, and presents it with a one-cycle valid strobe.
- The buffer consumes `sample` as its data input, one entry per strobe.

Parameters:
- SAMPLE_PERIOD, 1000: clk cycles between successive cs_n falling edges. Legal minimum is 34*SCLK_DIV+2; smaller values are clamped to that minimum.
- SCLK_DIV, 4: clk cycles per sclk half-period, ≥1.
- FRAME_BITS, 16: bits shifted per frame; fixed at 16 for this sensor.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; high = periodic sampling runs
- sclk  out  1  sensor serial clock, idles low
- cs_n  out  1  sensor chip select, active low, idles high
- miso  in  1  sensor serial data
- sample  out  8  last converted temperature, unsigned °C
- sample_valid  out  1  one-cycle strobe; sample is new this cycle
- busy  out  1  high while cs_n is low
- frame_err  out  1  one-cycle strobe, bad frame (optional feature only)

Behaviour:
- Reset (async, immediate):
  - Outputs: sclk=0, cs_n=1, sample=0, sample_valid=0, busy=0, frame_err=0.
  - State → IDLE; period counter and shift register cleared.
- States: IDLE, WAIT, CS_SETUP, SHIFT, CS_HOLD.
- IDLE:
  - enable=1 on a clock edge → CS_SETUP at that edge; cs_n falls at that edge.
  - The period counter starts at 0 at that same edge.
- CS_SETUP: cs_n=0, sclk=0 for SCLK_DIV cycles → SHIFT.
- SHIFT: 16 bits; for each bit:
  - sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - miso is captured into the LSB of the shift register (left shift) on the edge that drives sclk high.
  - After the 16th high phase, sclk → 0 and state → CS_HOLD.
- CS_HOLD: cs_n=0, sclk=0 for SCLK_DIV cycles. On the exiting edge:
  - cs_n → 1;
  - sample and sample_valid are updated on that same edge;
  - state → WAIT.
- Frame length: cs_n low for 34*SCLK_DIV cycles (136 at default).
- WAIT: when the period counter reaches SAMPLE_PERIOD-1:
  - enable=1 → start a new frame (CS_SETUP, counter reset to 0);
  - enable=0 → IDLE.
- Period counter: free-runs from each frame start; width is clog2(SAMPLE_PERIOD)+1.
- enable deasserted mid-frame: the current frame completes and publishes; no further frames start.
- Conversion:
  - Frame bits [15:7] form a 9-bit two's-complement whole-degree value.
  - Negative → sample=0; otherwise sample=bits[14:7]. Range 0..255; no rounding, fractional bits [6:0] are discarded.
- sample holds its value between strobes; sample_valid is never high for 2 consecutive cycles.
- busy = ~cs_n.
- Reset asserted mid-frame: the frame is abandoned, no strobe is issued, and cs_n rises immediately.

Optional Feature:
- Macro: TEMP_SAMPLER_FRAME_CHECK_EN.
- Defined:
  - Frame bits [1:0] must equal 2'b11 (sensor ID pattern).
  - On mismatch: frame_err pulses for 1 cycle on the edge where cs_n rises; sample_valid stays low; sample is unchanged.
  - On match: normal publish.
- Undefined: frame_err tied to 0 and every frame publishes.

Test Plan:
- Default parameters, enable=1, sensor returns 0x0C83 → cs_n low exactly 136 cycles, 16 sclk rising edges, sample=0x19 with sample_valid pulsing once as cs_n rises.
- Sensor returns 0xFF83 (-1 °C) → sample=0x00; returns 0x7F83 → sample=0xFF.
- enable held high for 3 frames → cs_n falling edges exactly 1000 cycles apart; 3 sample_valid pulses; busy matches ~cs_n throughout.
- enable dropped during bit 5 of a frame → that frame still publishes; no cs_n falling edge afterwards; state returns to IDLE.
- reset asserted during bit 10 → cs_n=1, sclk=0, sample=0 in the same cycle; no sample_valid; with enable=1 after release, a new frame starts on the next edge.
- TEMP_SAMPLER_FRAME_CHECK_EN defined, sensor returns 0x0C80 → frame_err=1 for 1 cycle, sample_valid=0, sample keeps its previous value; 0x0C83 → normal publish of 0x19.
